tile_fill_ctrl: RTL and testbench

TILE_FILL_CTRL -- requirements
Module: tile_fill_ctrl

---
 rtl/tile_fill_ctrl_pkg.sv | 14 +
 rtl/tile_fill_ctrl.sv | 80 ++++++++
 tb/tb_tile_fill_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tile_fill_ctrl_pkg.sv
// Shared constants and bank state encoding for the double-buffered tile fill controller.
package tile_fill_ctrl_pkg;

    localparam int unsigned WORDS_PER_TILE = 64;
    localparam int unsigned IDX_W          = 6;
    localparam int unsigned NUM_BANKS      = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } bank_state_t;

endpackage

// File: rtl/tile_fill_ctrl.sv
// Ping-pong fill controller: steers 4-byte words into one of two 16x16 tile banks
// and hands completed tiles to a consumer in fill order.
module tile_fill_ctrl
    import tile_fill_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load0,
    output logic             load1,
    output logic [IDX_W-1:0] index,
    output logic             tile_valid,
    output logic             tile_bank,
    input  logic             tile_ack,
    input  logic             flush,
    output logic [CNT_W-1:0] tiles_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_TILE - 1);

    bank_state_t      state [NUM_BANKS];
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] done_cnt;
    logic             accept;
    logic             release_tile;

    always_comb begin
        in_ready     = (state[wr_bank] != READY);
        accept       = in_valid & in_ready & ~flush;
        load0        = accept & (wr_bank == 1'b0);
        load1        = accept & (wr_bank == 1'b1);
        index        = idx;
        tile_valid   = (state[rd_bank] == READY);
        tile_bank    = rd_bank;
        release_tile = tile_ack & tile_valid;
        tiles_done   = done_cnt;
    end

    // Fill and release always touch different banks: a bank being written is never READY,
    // and release only applies to a READY bank, so both updates can land in one cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                state[b] <= EMPTY;
            end
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            idx      <= '0;
            done_cnt <= '0;
        end else begin
            if (flush) begin
                idx <= '0;
                if (state[wr_bank] == FILLING) begin
                    state[wr_bank] <= EMPTY;
                end
            end else if (accept) begin
                if (idx == LAST_IDX) begin
                    state[wr_bank] <= READY;
                    wr_bank        <= ~wr_bank;
                    idx            <= '0;
                    done_cnt       <= done_cnt + 1'b1;
                end else begin
                    state[wr_bank] <= FILLING;
                    idx            <= idx + 1'b1;
                end
            end

            if (release_tile) begin
                state[rd_bank] <= EMPTY;
                rd_bank        <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_tile_fill_ctrl.sv
// Directed self-checking bench for tile_fill_ctrl with hand-derived expectations.
module tb_tile_fill_ctrl;

    logic       clock = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       load0;
    logic       load1;
    logic [5:0] index;
    logic       tile_valid;
    logic       tile_bank;
    logic       tile_ack;
    logic       flush;
    logic [7:0] tiles_done;

    int checks = 0;
    int errors = 0;

    tile_fill_ctrl #(.CNT_W(8)) dut (
        .clock      (clock),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load0      (load0),
        .load1      (load1),
        .index      (index),
        .tile_valid (tile_valid),
        .tile_bank  (tile_bank),
        .tile_ack   (tile_ack),
        .flush      (flush),
        .tiles_done (tiles_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_load0"},      32'(load0),      32'd0);
        chk({tag, "_load1"},      32'(load1),      32'd0);
        chk({tag, "_index"},      32'(index),      32'd0);
        chk({tag, "_tile_valid"}, 32'(tile_valid), 32'd0);
        chk({tag, "_tile_bank"},  32'(tile_bank),  32'd0);
        chk({tag, "_tiles_done"}, 32'(tiles_done), 32'd0);
    endtask

    // Push n words into the bank given, checking index and strobes per word.
    task automatic push_words(input string tag, input int n, input int start, input logic bank);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            #1;
            chk({tag, "_index"}, 32'(index), 32'(start + i));
            chk({tag, "_load0"}, 32'(load0), 32'(bank == 1'b0));
            chk({tag, "_load1"}, 32'(load1), 32'(bank == 1'b1));
            tick();
        end
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; tile_ack = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");

        // One full tile into bank 0
        push_words("fill0", 64, 0, 1'b0);
        chk("fill0_tile_valid", 32'(tile_valid), 32'd1);
        chk("fill0_tile_bank",  32'(tile_bank),  32'd0);
        chk("fill0_tiles_done", 32'(tiles_done), 32'd1);
        chk("fill0_in_ready",   32'(in_ready),   32'd1);

        // Second tile into bank 1 with no ack: producer must stall
        push_words("fill1", 64, 0, 1'b1);
        chk("full_in_ready",   32'(in_ready),   32'd0);
        chk("full_tile_bank",  32'(tile_bank),  32'd0);
        chk("full_tiles_done", 32'(tiles_done), 32'd2);
        in_valid = 1'b1;
        #1;
        chk("refuse_load0", 32'(load0), 32'd0);
        chk("refuse_load1", 32'(load1), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("refuse_index",      32'(index),      32'd0);
        chk("refuse_tiles_done", 32'(tiles_done), 32'd2);
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
        #1;
        chk("ack0_tile_bank",  32'(tile_bank),  32'd1);
        chk("ack0_tile_valid", 32'(tile_valid), 32'd1);
        chk("ack0_in_ready",   32'(in_ready),   32'd1);

        // Release bank 1 so both banks are empty, rd=wr=0
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
        #1;
        chk("ack1_tile_valid", 32'(tile_valid), 32'd0);
        chk("ack1_tile_bank",  32'(tile_bank),  32'd0);

        // Flush after 20 words; flush beats in_valid
        push_words("pre_flush", 20, 0, 1'b0);
        flush = 1'b1; in_valid = 1'b1;
        #1;
        chk("flush_load0", 32'(load0), 32'd0);
        chk("flush_load1", 32'(load1), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_index",      32'(index),      32'd0);
        chk("flush_tile_valid", 32'(tile_valid), 32'd0);
        chk("flush_tiles_done", 32'(tiles_done), 32'd2);
        chk("flush_in_ready",   32'(in_ready),   32'd1);
        push_words("post_flush", 64, 0, 1'b0);
        chk("post_flush_tile_valid", 32'(tile_valid), 32'd1);
        chk("post_flush_tile_bank",  32'(tile_bank),  32'd0);
        chk("post_flush_tiles_done", 32'(tiles_done), 32'd3);

        // Bank 1 completes in the same cycle bank 0 is acked
        push_words("sim_fill", 63, 0, 1'b1);
        in_valid = 1'b1; tile_ack = 1'b1;
        #1;
        chk("sim_last_index", 32'(index), 32'd63);
        chk("sim_last_load1", 32'(load1), 32'd1);
        tick();
        in_valid = 1'b0; tile_ack = 1'b0;
        #1;
        chk("sim_tile_bank",  32'(tile_bank),  32'd1);
        chk("sim_tile_valid", 32'(tile_valid), 32'd1);
        chk("sim_in_ready",   32'(in_ready),   32'd1);
        chk("sim_tiles_done", 32'(tiles_done), 32'd4);

        // Drain bank 1, then an ack with nothing valid must be ignored
        tile_ack = 1'b1;
        tick();
        #1;
        chk("drain_tile_valid", 32'(tile_valid), 32'd0);
        chk("drain_tile_bank",  32'(tile_bank),  32'd0);
        tick();
        tile_ack = 1'b0;
        #1;
        chk("stray_ack_tile_bank",  32'(tile_bank),  32'd0);
        chk("stray_ack_tile_valid", 32'(tile_valid), 32'd0);

        // Reset at idx=37 with every other input active
        push_words("pre_rst", 37, 0, 1'b0);
        chk("pre_rst_index", 32'(index), 32'd37);
        rst = 1'b1; in_valid = 1'b1; tile_ack = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; tile_ack = 1'b0; flush = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        in_valid = 1'b1;
        #1;
        chk("post_rst_load0", 32'(load0), 32'd1);
        chk("post_rst_index", 32'(index), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_rst_next_index", 32'(index), 32'd1);

        // 256 tiles with ack held high: counter wraps to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; tile_ack = 1'b1;
        for (int t = 1; t <= 256; t++) begin
            for (int w = 0; w < 64; w++) begin
                tick();
            end
            if (t == 1 || t == 255 || t == 256) begin
                chk($sformatf("wrap_tiles_done_%0d", t), 32'(tiles_done), 32'(t % 256));
            end
        end
        in_valid = 1'b0; tile_ack = 1'b0;
        #1;
        chk("wrap_index", 32'(index), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
